// File: rtl/dct_coeff_sequencer.sv
// dct_coeff_sequencer
// Computes one 2-D 8x8 DCT coefficient: streams the 64 pixels of a block,
// weights each by a cosine term from an external combinational LUT,
// accumulates, rounds, saturates and hands the result off with valid/ready.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start, k1, k2       : job request and frequency indices (sampled in IDLE)
//   busy                : high whenever the sequencer is not idle
//   pix_re, pix_addr    : pixel buffer read port, address {n1,n2}
//   pix_rdata           : unsigned pixel, one cycle after pix_re
//   lut_k1/2, lut_n1/2  : cosine LUT select, n aligned with pix_rdata
//   cos_term            : signed cosine weight with FRAC_BITS fraction bits
//   out_valid/out_ready : coefficient handshake
//   coef                : rounded, saturated signed coefficient
module dct_coeff_sequencer #(
  parameter int unsigned FRAC_BITS = 10,
  parameter int unsigned COEF_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               k1,
  input  logic [2:0]               k2,
  output logic                     busy,
  output logic                     pix_re,
  output logic [5:0]               pix_addr,
  input  logic [7:0]               pix_rdata,
  output logic [2:0]               lut_k1,
  output logic [2:0]               lut_k2,
  output logic [2:0]               lut_n1,
  output logic [2:0]               lut_n2,
  input  logic signed [31:0]       cos_term,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] coef
);

  localparam int unsigned PROD_W = 41;
  localparam int unsigned ACC_W  = 48;
  localparam int unsigned RND_W  = ACC_W + 1;

  localparam logic signed [RND_W-1:0] C_HALF = RND_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [RND_W-1:0] C_MAX  = (RND_W'(1) << (COEF_W - 1)) - RND_W'(1);
  localparam logic signed [RND_W-1:0] C_MIN  = -(RND_W'(1) << (COEF_W - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     r_state;
  logic                       r_busy;
  logic                       r_pix_re;
  logic [5:0]                 r_pix_addr;   // doubles as the sample counter
  logic [2:0]                 r_lut_k1;
  logic [2:0]                 r_lut_k2;
  logic [2:0]                 r_lut_n1;
  logic [2:0]                 r_lut_n2;
  logic                       r_d_v;        // pix_rdata/cos_term valid this cycle
  logic                       r_p_v;        // r_prod valid this cycle
  logic                       r_drain;
  logic signed [PROD_W-1:0]   r_prod;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_out_valid;
  logic signed [COEF_W-1:0]   r_coef;

  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_acc_nxt;
  logic signed [RND_W-1:0]    w_rnd;
  logic signed [RND_W-1:0]    w_shf;
  logic signed [COEF_W-1:0]   w_coef;

  // Datapath: product, next accumulator value, round-half-up and saturate.
  // The coefficient is formed from the next accumulator so it can be
  // registered on the same edge that retires the last product.
  always_comb begin
    w_prod    = PROD_W'($signed({1'b0, pix_rdata})) * PROD_W'(cos_term);
    w_acc_nxt = r_acc + (r_p_v ? ACC_W'(r_prod) : '0);
    w_rnd     = RND_W'(w_acc_nxt) + C_HALF;
    w_shf     = w_rnd >>> FRAC_BITS;
    if (w_shf > C_MAX) begin
      w_coef = COEF_W'(C_MAX);
    end else if (w_shf < C_MIN) begin
      w_coef = COEF_W'(C_MIN);
    end else begin
      w_coef = COEF_W'(w_shf);
    end
  end

  // Control FSM and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_pix_re    <= 1'b0;
      r_pix_addr  <= '0;
      r_lut_k1    <= '0;
      r_lut_k2    <= '0;
      r_lut_n1    <= '0;
      r_lut_n2    <= '0;
      r_d_v       <= 1'b0;
      r_p_v       <= 1'b0;
      r_drain     <= 1'b0;
      r_prod      <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_coef      <= '0;
    end else begin
      r_d_v <= r_pix_re;
      r_p_v <= r_d_v;
      r_acc <= w_acc_nxt;
      if (r_d_v) begin
        r_prod <= w_prod;
      end
      if (r_pix_re) begin
        r_lut_n1 <= r_pix_addr[5:3];
        r_lut_n2 <= r_pix_addr[2:0];
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_lut_k1   <= k1;
            r_lut_k2   <= k2;
            r_acc      <= '0;
            r_d_v      <= 1'b0;
            r_p_v      <= 1'b0;
            r_pix_addr <= '0;
            r_pix_re   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (r_pix_addr == 6'd63) begin
            r_pix_re <= 1'b0;
            r_drain  <= 1'b0;
            r_state  <= DRAIN;
          end else begin
            r_pix_addr <= r_pix_addr + 6'd1;
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_coef      <= w_coef;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_drain <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign pix_re    = r_pix_re;
  assign pix_addr  = r_pix_addr;
  assign lut_k1    = r_lut_k1;
  assign lut_k2    = r_lut_k2;
  assign lut_n1    = r_lut_n1;
  assign lut_n2    = r_lut_n2;
  assign out_valid = r_out_valid;
  assign coef      = r_coef;

endmodule

// File: tb/tb_dct_coeff_sequencer.sv
// Directed self-checking bench for dct_coeff_sequencer.
// Models the pixel RAM (one-cycle read latency) and drives cos_term as a
// per-test constant; expected values are hand-computed.
module tb_dct_coeff_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [2:0]         k1;
  logic [2:0]         k2;
  logic               busy;
  logic               pix_re;
  logic [5:0]         pix_addr;
  logic [7:0]         pix_rdata = 8'd0;
  logic [2:0]         lut_k1;
  logic [2:0]         lut_k2;
  logic [2:0]         lut_n1;
  logic [2:0]         lut_n2;
  logic signed [31:0] cos_term;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] coef;

  logic [7:0] mem [64];
  int checks = 0;
  int errors = 0;
  int cyc;

  dct_coeff_sequencer #(.FRAC_BITS(10), .COEF_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .k1(k1), .k2(k2),
    .busy(busy), .pix_re(pix_re), .pix_addr(pix_addr), .pix_rdata(pix_rdata),
    .lut_k1(lut_k1), .lut_k2(lut_k2), .lut_n1(lut_n1), .lut_n2(lut_n2),
    .cos_term(cos_term), .out_valid(out_valid), .out_ready(out_ready),
    .coef(coef)
  );

  always #5 clk = ~clk;

  // Pixel RAM with one-cycle read latency.
  always @(posedge clk) if (pix_re) pix_rdata <= mem[pix_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic fill_addr();
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_pix_re"},    64'(pix_re),    64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_pix_addr"},  64'(pix_addr),  64'(0));
    chk({tag, "_lut_k1"},    64'(lut_k1),    64'(0));
    chk({tag, "_lut_k2"},    64'(lut_k2),    64'(0));
    chk({tag, "_lut_n1"},    64'(lut_n1),    64'(0));
    chk({tag, "_lut_n2"},    64'(lut_n2),    64'(0));
    chk({tag, "_coef"},      64'(coef),      64'(0));
  endtask

  // Drives start for cycle 0; returns at the cycle-1 sample point.
  task automatic start_job(input logic [2:0] a, input logic [2:0] b);
    start = 1'b1;
    k1 = a;
    k2 = b;
    tick();
    start = 1'b0;
  endtask

  // Called at cycle 1; returns the cycle index where out_valid is first seen.
  task automatic wait_valid(output int c);
    c = 1;
    while (!out_valid && c < 200) begin
      tick();
      c++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_busy"},  64'(busy),      64'(0));
    chk({tag, "_hs_valid"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k1 = 3'd0; k2 = 3'd0;
    out_ready = 1'b0; cos_term = 32'sd0;
    fill_const(8'd0);
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Nominal: 64 * 255 * 1024 -> 16320, valid at cycle 67.
    cos_term = 32'sd1024;
    fill_const(8'd255);
    start_job(3'd0, 3'd0);
    chk("t1_busy", 64'(busy), 64'(1));
    wait_valid(cyc);
    chk("t1_latency", 64'(cyc), 64'(67));
    chk("t1_coef", 64'(coef), 64'(16320));
    handshake("t1");

    // Positive saturation.
    cos_term = 32'h7FFFFFFF;
    start_job(3'd1, 3'd3);
    wait_valid(cyc);
    chk("t2_latency", 64'(cyc), 64'(67));
    chk("t2_coef", 64'(coef), 64'(32767));
    handshake("t2");

    // Negative saturation.
    cos_term = 32'h80000000;
    start_job(3'd7, 3'd7);
    wait_valid(cyc);
    chk("t3_coef", 64'(coef), 64'(-32768));
    handshake("t3");

    // Address sequence and LUT alignment; sum 0..63 = 2016 -> coef 2016.
    cos_term = 32'sd1024;
    fill_addr();
    start_job(3'd5, 3'd2);
    for (int c = 1; c <= 64; c++) begin
      chk("t4_pix_re", 64'(pix_re), 64'(1));
      chk("t4_pix_addr", 64'(pix_addr), 64'(c - 1));
      chk("t4_lut_k1", 64'(lut_k1), 64'(5));
      chk("t4_lut_k2", 64'(lut_k2), 64'(2));
      if (c >= 2) begin
        chk("t4_lut_n1", 64'(lut_n1), 64'((c - 2) >> 3));
        chk("t4_lut_n2", 64'(lut_n2), 64'((c - 2) & 7));
        chk("t4_rdata", 64'(pix_rdata), 64'(c - 2));
      end
      tick();
    end
    chk("t4_drain_re", 64'(pix_re), 64'(0));
    chk("t4_drain_busy", 64'(busy), 64'(1));
    chk("t4_drain_n1", 64'(lut_n1), 64'(7));
    chk("t4_drain_n2", 64'(lut_n2), 64'(7));
    chk("t4_drain_valid", 64'(out_valid), 64'(0));
    tick();
    chk("t4_c66_valid", 64'(out_valid), 64'(0));
    tick();
    chk("t4_c67_valid", 64'(out_valid), 64'(1));
    chk("t4_coef", 64'(coef), 64'(2016));
    chk("t4_done_re", 64'(pix_re), 64'(0));

    // Back-pressure: hold for 10 cycles with a start pulse, then handshake
    // with start also high.
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      k1 = 3'd1;
      chk("t5_hold_valid", 64'(out_valid), 64'(1));
      chk("t5_hold_coef", 64'(coef), 64'(2016));
      chk("t5_hold_k1", 64'(lut_k1), 64'(5));
      chk("t5_hold_re", 64'(pix_re), 64'(0));
      tick();
    end
    start = 1'b1;
    handshake("t5");
    chk("t5_hs_re", 64'(pix_re), 64'(0));
    start = 1'b0;
    tick();
    chk("t5_idle_busy", 64'(busy), 64'(0));
    chk("t5_idle_re", 64'(pix_re), 64'(0));

    // Reset mid-RUN at cycle 30, then a clean job: 64 * 1 * 1024 -> 64.
    cos_term = 32'sd1024;
    fill_const(8'd255);
    start_job(3'd3, 3'd4);
    for (int i = 1; i < 30; i++) tick();
    chk("t6_c30_re", 64'(pix_re), 64'(1));
    chk("t6_c30_addr", 64'(pix_addr), 64'(29));
    rst = 1'b1;
    tick();
    chk_zero("t6_abort");
    rst = 1'b0;
    fill_const(8'd1);
    tick();
    start_job(3'd0, 3'd0);
    wait_valid(cyc);
    chk("t6_latency", 64'(cyc), 64'(67));
    chk("t6_coef", 64'(coef), 64'(64));
    handshake("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dct_coeff_sequencer.md
DCT_COEFF_SEQUENCER -- requirements
Module: dct_coeff_sequencer

Interface
REQ-001 The block SHALL have parameter FRAC_BITS, default 10, giving the number of fractional bits in cos_term.
REQ-002 The block SHALL have parameter COEF_W, default 16, giving the output coefficient width (signed).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request one coefficient computation.
REQ-006 Port k1, input, 3: vertical frequency index, sampled on start accept.
REQ-007 Port k2, input, 3: horizontal frequency index, sampled on start accept.
REQ-008 Port busy, output, 1: high in every state except IDLE.
REQ-009 Port pix_re, output, 1: pixel buffer read enable.
REQ-010 Port pix_addr, output, 6: pixel address {n1,n2}.
REQ-011 Port pix_rdata, input, 8: unsigned pixel; valid one cycle after pix_re/pix_addr.
REQ-012 Port lut_k1, output, 3: latched k1, selecting the cosine LUT bank.
REQ-013 Port lut_k2, output, 3: latched k2, selecting the cosine LUT bank.
REQ-014 Port lut_n1, output, 3: registered n1, aligned with pix_rdata.
REQ-015 Port lut_n2, output, 3: registered n2, aligned with pix_rdata.
REQ-016 Port cos_term, input, 32: signed cosine weight from the combinational LUT, driven by lut_k*/lut_n*.
REQ-017 Port out_valid, output, 1: coefficient available.
REQ-018 Port out_ready, input, 1: consumer accepts the coefficient.
REQ-019 Port coef, output, COEF_W: signed DCT coefficient.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, RUN, DRAIN and DONE.
REQ-021 IDLE with start=1 (cycle 0) SHALL latch k1/k2, clear the accumulator and counter, and go to RUN; start SHALL be ignored outside IDLE.
REQ-022 RUN SHALL last 64 cycles (cycles 1..64), asserting pix_re=1 with pix_addr = counter 0..63; n1=addr[5:3], n2=addr[2:0] (n2 fastest).
REQ-023 lut_n1/lut_n2 SHALL be the previous cycle's n1/n2, so that cos_term and pix_rdata refer to the same sample.
REQ-024 The product pix_rdata (zero-extended) × cos_term SHALL be registered as a 41-bit signed value (stage 1), then added into a 48-bit signed accumulator the following cycle (stage 2).
REQ-025 DRAIN SHALL last 2 cycles (65..66), with pix_re=0, flushing both stages.
REQ-026 DONE SHALL be entered with out_valid=1 from cycle 67, with the accumulator holding the sum of all 64 products.
REQ-027 coef SHALL equal (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, saturated to [-2^(COEF_W-1), 2^(COEF_W-1)-1].
REQ-028 In DONE, out_valid and coef SHALL hold stable until out_ready=1; on out_valid&out_ready the FSM SHALL go to IDLE next cycle.
REQ-029 start asserted in the handshake cycle SHALL be ignored; a new job SHALL be accepted only from IDLE.
REQ-030 pix_re SHALL be 0 in IDLE, DRAIN and DONE; lut_k1/lut_k2 SHALL stay constant for the whole job.

Reset
REQ-031 On rst=1, regardless of state (including mid-RUN/DRAIN/DONE), the next state SHALL be IDLE.
REQ-032 On rst=1, busy, pix_re, out_valid SHALL be 0; pix_addr, lut_k*, lut_n*, coef, accumulator, product register and counter SHALL be 0.
REQ-033 The first start after reset release SHALL compute a result independent of any aborted job.

Verification
REQ-034 Bench LUT cos_term=1024, all pixels 255, start at cycle 0 -> out_valid first high at cycle 67, coef=16320.
REQ-035 Bench LUT cos_term=32'h7FFFFFFF, pixels 255 -> coef=32767; cos_term=32'h80000000 -> coef=-32768.
REQ-036 Pixel RAM holding addr value, k1=5,k2=2 -> pix_addr sequence 0..63 in cycles 1..64, lut_k1=5, lut_k2=2, lut_n1/lut_n2 lagging by one cycle.
REQ-037 out_ready low for 10 cycles after out_valid, start pulsed -> coef stable, no new job; out_ready=1 -> IDLE next cycle.
REQ-038 rst at cycle 30 of a job -> all outputs 0 next cycle; new start with cos_term=1024, pixels 1 -> coef=64.
